// File: rtl/spi_mem_pkg.sv
// Shared FSM state encodings and command codes for the SPI-to-memory bridge.
package spi_mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CMD     = 3'd1;
  localparam state_t S_WR_ADDR = 3'd2;
  localparam state_t S_WR_DATA = 3'd3;
  localparam state_t S_RD_ADDR = 3'd4;
  localparam state_t S_RD_TURN = 3'd5;
  localparam state_t S_RD_DATA = 3'd6;
  // Address received; swallow the rest of the frame until SS_n rises.
  localparam state_t S_WAIT    = 3'd7;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_array.sv
// Register-file storage: one synchronous write port, one combinational read port.
module spi_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI-slave front end that decodes framed commands into burst writes and
// gap-free burst reads of an internal register-file memory.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  localparam int MAXW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CW-1:0]         ADDR_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST  = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic                  r_cmd_hi;
  logic [CW-1:0]         r_cnt;
  logic [MAXW-2:0]       r_rx;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_miso;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;

  logic [MAXW-1:0]       w_rx_next;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic                  w_addr_ok;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_we;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign w_rx_next    = {r_rx, MOSI};
  assign w_addr_in    = w_rx_next[ADDR_WIDTH-1:0];
  assign w_addr_ok    = {1'b0, w_addr_in} < DEPTH_W;
  assign w_wr_ptr_inc = ptr_inc(r_wr_ptr);
  assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);

  // While streaming, the single read port looks one word ahead so the next
  // MSB is ready at the word boundary with no idle bit.
  assign w_rd_addr = (r_state == S_RD_DATA) ? w_rd_ptr_inc : r_rd_ptr;

  assign w_we = rst_n && !SS_n && (r_state == S_WR_DATA) && (r_cnt == DATA_LAST);

  spi_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(w_rx_next[DATA_WIDTH-1:0]),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cmd_hi <= 1'b0;
      r_cnt    <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_miso   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (SS_n) begin
      // Frame ended: any partial word or address is simply dropped.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
    end else begin
      r_miso <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_hi <= MOSI;
          r_cnt    <= '0;
          r_state  <= S_CMD;
        end
        S_CMD: begin
          r_cnt <= '0;
          case ({r_cmd_hi, MOSI})
            CMD_WR_ADDR: r_state <= S_WR_ADDR;
            CMD_WR_DATA: r_state <= S_WR_DATA;
            CMD_RD_ADDR: r_state <= S_RD_ADDR;
            default:     r_state <= S_RD_TURN;
          endcase
        end
        S_WR_ADDR, S_RD_ADDR: begin
          r_rx <= w_rx_next[MAXW-2:0];
          if (r_cnt == ADDR_LAST) begin
            if (w_addr_ok && r_state == S_WR_ADDR) r_wr_ptr <= w_addr_in;
            if (w_addr_ok && r_state == S_RD_ADDR) r_rd_ptr <= w_addr_in;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR_DATA: begin
          r_rx <= w_rx_next[MAXW-2:0];
          if (r_cnt == DATA_LAST) begin
            r_wr_ptr <= w_wr_ptr_inc;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD_TURN: begin
          r_miso  <= w_rd_data[DATA_WIDTH-1];
          r_tx    <= w_rd_data << 1;
          r_cnt   <= '0;
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (r_cnt == DATA_LAST) begin
            r_miso   <= w_rd_data[DATA_WIDTH-1];
            r_tx     <= w_rd_data << 1;
            r_rd_ptr <= w_rd_ptr_inc;
            r_cnt    <= '0;
          end else begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= r_tx << 1;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign MISO = r_miso;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench: two bridges (full 256-word and a 200-word instance) driven
// through SPI frames, checked against hand-computed values.
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mosi = 1'b0;
  logic ss_n = 1'b1;
  logic use_b = 1'b0;
  logic ss_a, ss_b, miso_a, miso_b, miso_sel;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign ss_a = use_b ? 1'b1 : ss_n;
  assign ss_b = use_b ? ss_n : 1'b1;
  assign miso_sel = use_b ? miso_b : miso_a;

  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss_a), .MISO(miso_a)
  );

  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss_b), .MISO(miso_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One clock edge with the given pins; outputs are sampled 1 time unit later.
  task automatic step(input logic ss, input logic b);
    ss_n = ss;
    mosi = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, val[i]);
  endtask

  task automatic end_frame();
    step(1'b1, 1'b0);
  endtask

  task automatic frame(input logic [1:0] cmd, input logic [31:0] val, input int n);
    send_bits({30'd0, cmd}, 2);
    send_bits(val, n);
    end_frame();
  endtask

  task automatic read_bits(input int n, output logic [31:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      word = {word[30:0], miso_sel};
    end
  endtask

  logic [31:0] rd;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    rst_n = 1'b1;
    check("reset_miso", 32'(miso_a), 32'd0);
    check("reset_state", 32'(dut_a.r_state), 32'd0);
    check("reset_wr_ptr", 32'(dut_a.r_wr_ptr), 32'd0);
    check("reset_rd_ptr", 32'(dut_a.r_rd_ptr), 32'd0);

    // Single write and read-back of 0xA5 at 0x10
    frame(2'b00, 32'h10, 8);
    check("wr_addr_load", 32'(dut_a.r_wr_ptr), 32'h10);
    frame(2'b01, 32'hA5, 8);
    check("mem_10", 32'(dut_a.u_array.r_mem[8'h10]), 32'hA5);
    check("wr_ptr_inc", 32'(dut_a.r_wr_ptr), 32'h11);
    frame(2'b10, 32'h10, 8);
    check("rd_addr_load", 32'(dut_a.r_rd_ptr), 32'h10);
    step(1'b0, 1'b1);
    check("miso_e0", 32'(miso_sel), 32'd0);
    step(1'b0, 1'b1);
    check("miso_e1", 32'(miso_sel), 32'd0);
    read_bits(8, rd);
    check("read_a5", rd, 32'hA5);
    end_frame();
    check("miso_after", 32'(miso_sel), 32'd0);
    check("rd_ptr_partial", 32'(dut_a.r_rd_ptr), 32'h10);

    // Burst write with wrap at end of memory
    frame(2'b00, 32'hFE, 8);
    frame(2'b01, 32'h112233, 24);
    check("mem_fe", 32'(dut_a.u_array.r_mem[8'hFE]), 32'h11);
    check("mem_ff", 32'(dut_a.u_array.r_mem[8'hFF]), 32'h22);
    check("mem_00", 32'(dut_a.u_array.r_mem[8'h00]), 32'h33);
    check("wr_ptr_wrap", 32'(dut_a.r_wr_ptr), 32'h01);

    // Gap-free burst read across the wrap
    frame(2'b10, 32'hFE, 8);
    send_bits(32'h3, 2);
    read_bits(24, rd);
    check("burst_read", rd, 32'h112233);
    end_frame();

    // Aborted write after 5 data bits
    frame(2'b00, 32'h40, 8);
    frame(2'b01, 32'h3C, 8);
    send_bits(32'h1, 2);
    send_bits(32'h16, 5);
    end_frame();
    check("abort_wr_ptr", 32'(dut_a.r_wr_ptr), 32'h41);
    check("abort_mem_40", 32'(dut_a.u_array.r_mem[8'h40]), 32'h3C);
    frame(2'b10, 32'h40, 8);
    send_bits(32'h3, 2);
    read_bits(8, rd);
    end_frame();
    check("after_abort_read", rd, 32'h3C);

    // Reset in the middle of a read
    frame(2'b10, 32'h10, 8);
    send_bits(32'h3, 2);
    read_bits(4, rd);
    check("pre_reset_nibble", rd, 32'hA);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    check("rst_mid_miso", 32'(miso_sel), 32'd0);
    check("rst_mid_state", 32'(dut_a.r_state), 32'd0);
    check("rst_mid_rd_ptr", 32'(dut_a.r_rd_ptr), 32'd0);
    rst_n = 1'b1;
    end_frame();
    frame(2'b10, 32'h10, 8);
    send_bits(32'h3, 2);
    read_bits(8, rd);
    end_frame();
    check("mem_survives_rst", rd, 32'hA5);

    // 200-word instance: out-of-range address and wrap at 199
    use_b = 1'b1;
    end_frame();
    frame(2'b10, 32'h05, 8);
    check("b_rd_ptr_05", 32'(dut_b.r_rd_ptr), 32'h05);
    frame(2'b10, 32'hC8, 8);
    check("b_rd_ptr_ignored", 32'(dut_b.r_rd_ptr), 32'h05);
    frame(2'b00, 32'hC7, 8);
    check("b_wr_ptr_c7", 32'(dut_b.r_wr_ptr), 32'hC7);
    frame(2'b01, 32'h5A6B, 16);
    check("b_mem_c7", 32'(dut_b.u_array.r_mem[8'hC7]), 32'h5A);
    check("b_mem_00", 32'(dut_b.u_array.r_mem[8'h00]), 32'h6B);
    check("b_wr_ptr_wrap", 32'(dut_b.r_wr_ptr), 32'h01);
    frame(2'b10, 32'hC7, 8);
    send_bits(32'h3, 2);
    read_bits(16, rd);
    end_frame();
    check("b_burst_read", rd, 32'h5A6B);
    check("b_miso_idle", 32'(miso_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
